// File: rtl/led_display_scheduler_if.sv
// Request/acknowledge bundle between the display scheduler and the
// serial LED driver (led_write FSM).
`timescale 1ns/1ps
interface led_display_scheduler_if;
    // Handshake: control_write / dot_write are single-cycle requests, never
    // high together; at most one request is outstanding, and the driver ends
    // it with a single-cycle write_end pulse. control_word and char0..3 are
    // stable from the cycle after the request until the next request.
    logic       control_write;
    logic       dot_write;
    logic [7:0] control_word;
    logic [7:0] char0;
    logic [7:0] char1;
    logic [7:0] char2;
    logic [7:0] char3;
    logic       write_end;

    modport master (
        output control_write, dot_write, control_word,
        output char0, char1, char2, char3,
        input  write_end
    );

    modport slave (
        input  control_write, dot_write, control_word,
        input  char0, char1, char2, char3,
        output write_end
    );
endinterface

// File: rtl/led_display_scheduler.sv
// Buffers received characters as a message and schedules control-word and
// dot-register writes to the LED driver, one outstanding write at a time.
`timescale 1ns/1ps
module led_display_scheduler #(
    parameter int         MSG_DEPTH = 16,
    parameter int         TIMEOUT   = 4095,
    parameter logic [7:0] PAD_CHAR  = 8'h20
) (
    input  logic                       led_clk,
    input  logic                       rstn,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    input  logic [7:0]                 ctrl_word_in,
    input  logic                       ctrl_update,
    input  logic                       scrolling_enable,
    input  logic                       tick,
    led_display_scheduler_if.master    drv,
    output logic [$clog2(MSG_DEPTH):0] msg_len,
    output logic                       overflow,
    output logic                       timeout_err,
    output logic [2:0]                 state_dbg
);
    localparam int         PW       = $clog2(MSG_DEPTH);
    localparam int         LW       = PW + 1;
    localparam int         TW       = $clog2(TIMEOUT + 1);
    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] CW_RESET = 8'h4F;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CTRL_REQ  = 3'd1,
        CTRL_WAIT = 3'd2,
        DOT_REQ   = 3'd3,
        DOT_WAIT  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      mem_q [MSG_DEPTH];
    logic [7:0]      mem_d [MSG_DEPTH];
    logic [LW-1:0]   len_q, len_d;
    logic [PW-1:0]   sptr_q, sptr_d;
    logic            ovf_q, ovf_d;
    logic            terr_q, terr_d;
    logic [7:0]      shadow_q, shadow_d;
    logic            ctrl_pend_q, ctrl_pend_d;
    logic            tick_pend_q, tick_pend_d;
    logic [7:0]      cw_q, cw_d;
    logic [7:0]      chr_q [4];
    logic [7:0]      chr_d [4];
    logic            ctrl_wr, dot_wr;
    logic [PW-1:0]   scroll_idx, scroll_nxt;

    // A scroll pointer left beyond the message (after a CR) restarts at 0.
    assign scroll_idx = ({1'b0, sptr_q} >= len_q) ? '0 : sptr_q;
    assign scroll_nxt = (({1'b0, scroll_idx} + LW'(1)) >= len_q) ? '0 : scroll_idx + PW'(1);

    // Next-state, request strobes, character load, message buffer, pending flags.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        mem_d       = mem_q;
        len_d       = len_q;
        sptr_d      = sptr_q;
        ovf_d       = ovf_q;
        terr_d      = terr_q;
        shadow_d    = shadow_q;
        ctrl_pend_d = ctrl_pend_q;
        tick_pend_d = tick_pend_q;
        cw_d        = cw_q;
        chr_d       = chr_q;
        ctrl_wr     = 1'b0;
        dot_wr      = 1'b0;

        case (state_q)
            IDLE: begin
                // Control updates take priority over dot refreshes.
                if (ctrl_pend_q) begin
                    state_d = CTRL_REQ;
                end else if (tick_pend_q) begin
                    if (len_q != '0) state_d = DOT_REQ;
                    else             tick_pend_d = 1'b0;
                end
            end
            CTRL_REQ: begin
                ctrl_wr     = 1'b1;
                cw_d        = shadow_q;
                ctrl_pend_d = 1'b0;
                timer_d     = '0;
                state_d     = CTRL_WAIT;
            end
            DOT_REQ: begin
                dot_wr      = 1'b1;
                tick_pend_d = 1'b0;
                timer_d     = '0;
                state_d     = DOT_WAIT;
                if (scrolling_enable) begin
                    chr_d[0] = mem_q[scroll_idx];
                    sptr_d   = scroll_nxt;
                end else begin
                    for (int n = 0; n < 4; n++) begin
                        chr_d[n] = (LW'(n) < len_q) ? mem_q[n[PW-1:0]] : PAD_CHAR;
                    end
                end
            end
            CTRL_WAIT, DOT_WAIT: begin
                if (drv.write_end) begin
                    state_d = IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The buffer accepts characters in every state; a CR also overrides
        // any scroll-pointer advance made in the same cycle.
        if (rx_valid) begin
            if (rx_data == CR) begin
                len_d  = '0;
                sptr_d = '0;
                ovf_d  = 1'b0;
            end else if (len_q < LW'(MSG_DEPTH)) begin
                mem_d[len_q[PW-1:0]] = rx_data;
                len_d                = len_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        // Set strobes come last so they win over a same-cycle clear.
        if (ctrl_update) begin
            shadow_d    = ctrl_word_in;
            ctrl_pend_d = 1'b1;
        end
        if (tick) tick_pend_d = 1'b1;
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge led_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            mem_q       <= '{default: 8'h00};
            len_q       <= '0;
            sptr_q      <= '0;
            ovf_q       <= 1'b0;
            terr_q      <= 1'b0;
            shadow_q    <= '0;
            ctrl_pend_q <= 1'b0;
            tick_pend_q <= 1'b0;
            cw_q        <= CW_RESET;
            chr_q       <= '{default: PAD_CHAR};
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            mem_q       <= mem_d;
            len_q       <= len_d;
            sptr_q      <= sptr_d;
            ovf_q       <= ovf_d;
            terr_q      <= terr_d;
            shadow_q    <= shadow_d;
            ctrl_pend_q <= ctrl_pend_d;
            tick_pend_q <= tick_pend_d;
            cw_q        <= cw_d;
            chr_q       <= chr_d;
        end
    end

    assign drv.control_write = ctrl_wr;
    assign drv.dot_write     = dot_wr;
    assign drv.control_word  = cw_q;
    assign drv.char0         = chr_q[0];
    assign drv.char1         = chr_q[1];
    assign drv.char2         = chr_q[2];
    assign drv.char3         = chr_q[3];
    assign msg_len           = len_q;
    assign overflow          = ovf_q;
    assign timeout_err       = terr_q;
    assign state_dbg         = state_q;
endmodule

// File: tb/tb_led_display_scheduler.sv
// Self-checking bench for led_display_scheduler: directed scenarios with
// literal expectations plus a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_led_display_scheduler;
    localparam int DEPTH = 16;
    localparam int TO    = 300;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          led_clk = 1'b0;
    logic          rstn    = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic [7:0]    ctrl_word_in = '0;
    logic          ctrl_update = 1'b0;
    logic          scrolling_enable = 1'b1;
    logic          tick = 1'b0;
    logic [LW-1:0] msg_len;
    logic          overflow;
    logic          timeout_err;
    logic [2:0]    state_dbg;

    led_display_scheduler_if drv_if();

    led_display_scheduler #(.MSG_DEPTH(DEPTH), .TIMEOUT(TO), .PAD_CHAR(8'h20)) dut (
        .led_clk          (led_clk),
        .rstn             (rstn),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .ctrl_word_in     (ctrl_word_in),
        .ctrl_update      (ctrl_update),
        .scrolling_enable (scrolling_enable),
        .tick             (tick),
        .drv              (drv_if.master),
        .msg_len          (msg_len),
        .overflow         (overflow),
        .timeout_err      (timeout_err),
        .state_dbg        (state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 led_clk = ~led_clk;

    int cyc = 0;
    always @(posedge led_clk) cyc++;

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_mem [DEPTH];
    logic [7:0] m_chr [4];
    int         m_len, m_sptr, m_age;
    int         m_issue;     // request visible this cycle: 0 none, 1 control, 2 dot
    bit         m_busy;      // a request was issued and is awaiting write_end
    bit         m_ovf, m_terr, m_ctrl_pend, m_tick_pend;
    logic [7:0] m_shadow, m_cw;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) m_chr[i] = 8'h20;
        m_len = 0; m_sptr = 0; m_age = 0; m_issue = 0; m_busy = 0;
        m_ovf = 0; m_terr = 0; m_ctrl_pend = 0; m_tick_pend = 0;
        m_shadow = 8'h00; m_cw = 8'h4F;
    endtask

    task automatic model_step();
        int nxt;
        int s;
        nxt = 0;
        if (m_issue == 1) begin
            m_cw = m_shadow;
            m_ctrl_pend = 0;
            m_busy = 1;
            m_age = 0;
        end else if (m_issue == 2) begin
            if (scrolling_enable) begin
                s = (m_sptr >= m_len) ? 0 : m_sptr;
                m_chr[0] = m_mem[s];
                m_sptr = (s + 1 >= m_len) ? 0 : s + 1;
            end else begin
                for (int n = 0; n < 4; n++) m_chr[n] = (n < m_len) ? m_mem[n] : 8'h20;
            end
            m_tick_pend = 0;
            m_busy = 1;
            m_age = 0;
        end else if (m_busy) begin
            if (drv_if.write_end) begin
                m_busy = 0;
            end else begin
                m_age++;
                if (m_age == TO) begin
                    m_busy = 0;
                    m_terr = 1;
                end
            end
        end else begin
            if (m_ctrl_pend) nxt = 1;
            else if (m_tick_pend) begin
                if (m_len != 0) nxt = 2;
                else m_tick_pend = 0;
            end
        end
        m_issue = nxt;
        if (rx_valid) begin
            if (rx_data == 8'h0D) begin
                m_len = 0; m_sptr = 0; m_ovf = 0;
            end else if (m_len < DEPTH) begin
                m_mem[m_len] = rx_data;
                m_len++;
            end else begin
                m_ovf = 1;
            end
        end
        if (ctrl_update) begin
            m_shadow = ctrl_word_in;
            m_ctrl_pend = 1;
        end
        if (tick) m_tick_pend = 1;
    endtask

    always @(posedge led_clk or negedge rstn) begin
        if (!rstn) model_reset();
        else       model_step();
    end

    // ---------------- compare process and monitors ----------------
    int         dot_cnt = 0;
    int         ctrl_cnt = 0;
    int         pulse_log[$];
    logic [7:0] cap_log[$];
    bit         cap_pending = 0;

    always @(negedge led_clk) begin
        chk("control_write", 32'(drv_if.control_write), 32'(m_issue == 1));
        chk("dot_write", 32'(drv_if.dot_write), 32'(m_issue == 2));
        chk("req_exclusive", 32'(drv_if.control_write & drv_if.dot_write), 32'd0);
        chk("control_word", 32'(drv_if.control_word), 32'(m_cw));
        chk("char0", 32'(drv_if.char0), 32'(m_chr[0]));
        chk("char1", 32'(drv_if.char1), 32'(m_chr[1]));
        chk("char2", 32'(drv_if.char2), 32'(m_chr[2]));
        chk("char3", 32'(drv_if.char3), 32'(m_chr[3]));
        chk("msg_len", 32'(msg_len), 32'(m_len));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));

        if (cap_pending) cap_log.push_back(drv_if.char0);
        cap_pending = drv_if.dot_write;
        if (drv_if.dot_write) begin
            dot_cnt++;
            pulse_log.push_back(2);
        end
        if (drv_if.control_write) begin
            ctrl_cnt++;
            pulse_log.push_back(1);
        end
    end

    // ---------------- driver responder ----------------
    int ack_mode = 1;   // 0 never acknowledge, 1 fixed delay, 2 random delay
    int ack_delay = 3;
    int ack_cnt = 0;

    initial begin
        drv_if.write_end = 1'b0;
        forever begin
            @(posedge led_clk); #1;
            drv_if.write_end = 1'b0;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) drv_if.write_end = 1'b1;
            end else if ((drv_if.dot_write || drv_if.control_write) && ack_mode != 0) begin
                ack_cnt = (ack_mode == 1) ? ack_delay : int'($urandom_range(1, 8));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge led_clk); #1;
    endtask

    task automatic send_char(input logic [7:0] c);
        rx_data = c;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic wait_dot(input string name, input int bound);
        int i;
        i = 0;
        while (!drv_if.dot_write && i < bound) begin
            step();
            i++;
        end
        if (!drv_if.dot_write) begin
            checks++;
            errors++;
            $display("FAIL %s: no dot_write within %0d cycles", name, bound);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] exp_q[$];
    int         d0, c0, t0;
    logic [7:0] got;

    initial begin
        repeat (3) @(posedge led_clk);
        #1;
        chk("rst_control_word", 32'(drv_if.control_word), 32'h4F);
        chk("rst_char0", 32'(drv_if.char0), 32'h20);
        chk("rst_char3", 32'(drv_if.char3), 32'h20);
        chk("rst_msg_len", 32'(msg_len), 32'd0);
        chk("rst_dot_write", 32'(drv_if.dot_write), 32'd0);
        rstn = 1'b1;
        step();

        // Scroll through "ABCDE" with six ticks.
        scrolling_enable = 1'b1;
        send_str("ABCDE");
        cap_log.delete();
        d0 = dot_cnt;
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h41};
        repeat (6) begin
            pulse_tick();
            repeat (10) step();
        end
        chk("scroll_pulses", 32'(dot_cnt - d0), 32'd6);
        chk("scroll_msg_len", 32'(msg_len), 32'd5);
        chk("scroll_captures", 32'(cap_log.size()), 32'd6);
        while (exp_q.size() != 0 && cap_log.size() != 0) begin
            got = cap_log.pop_front();
            chk("scroll_char0", 32'(got), 32'(exp_q.pop_front()));
        end

        // Static display of "HI", with tick-to-request latency.
        scrolling_enable = 1'b0;
        send_char(8'h0D);
        send_str("HI");
        t0 = cyc;
        pulse_tick();
        wait_dot("static_dot", 10);
        chk("static_latency", 32'(cyc - t0), 32'd2);
        repeat (10) step();
        chk("static_char0", 32'(drv_if.char0), 32'h48);
        chk("static_char1", 32'(drv_if.char1), 32'h49);
        chk("static_char2", 32'(drv_if.char2), 32'h20);
        chk("static_char3", 32'(drv_if.char3), 32'h20);

        // Control update and tick together: control goes first.
        pulse_log.delete();
        ctrl_word_in = 8'h3A;
        ctrl_update = 1'b1;
        tick = 1'b1;
        step();
        ctrl_update = 1'b0;
        tick = 1'b0;
        repeat (20) step();
        chk("arb_pulse_count", 32'(pulse_log.size()), 32'd2);
        if (pulse_log.size() >= 2) begin
            chk("arb_first_ctrl", 32'(pulse_log[0]), 32'd1);
            chk("arb_second_dot", 32'(pulse_log[1]), 32'd2);
        end
        chk("arb_control_word", 32'(drv_if.control_word), 32'h3A);

        // Overflow on a full buffer, cleared by CR; tick on empty message is dropped.
        send_char(8'h0D);
        for (int i = 0; i < 17; i++) send_char(8'(8'h61 + i));
        chk("full_msg_len", 32'(msg_len), 32'd16);
        chk("full_overflow", 32'(overflow), 32'd1);
        send_char(8'h0D);
        chk("cr_msg_len", 32'(msg_len), 32'd0);
        chk("cr_overflow", 32'(overflow), 32'd0);
        d0 = dot_cnt;
        pulse_tick();
        repeat (10) step();
        chk("empty_no_dot", 32'(dot_cnt - d0), 32'd0);

        // Withheld write_end leads to a timeout, then normal service resumes.
        ack_mode = 0;
        send_char(8'h5A);
        pulse_tick();
        wait_dot("timeout_dot", 10);
        repeat (TO - 3) step();
        chk("timeout_not_yet", 32'(timeout_err), 32'd0);
        repeat (10) step();
        chk("timeout_set", 32'(timeout_err), 32'd1);
        ack_mode = 1;
        d0 = dot_cnt;
        pulse_tick();
        repeat (10) step();
        chk("after_timeout_dot", 32'(dot_cnt - d0), 32'd1);

        // Reset in the middle of a dot write; the late write_end is ignored.
        ack_delay = 6;
        pulse_tick();
        wait_dot("reset_dot", 10);
        step();
        step();
        rstn = 1'b0;
        #1;
        chk("mid_rst_control_word", 32'(drv_if.control_word), 32'h4F);
        chk("mid_rst_char0", 32'(drv_if.char0), 32'h20);
        chk("mid_rst_char1", 32'(drv_if.char1), 32'h20);
        chk("mid_rst_msg_len", 32'(msg_len), 32'd0);
        chk("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("mid_rst_dot_write", 32'(drv_if.dot_write), 32'd0);
        step();
        rstn = 1'b1;
        d0 = dot_cnt;
        c0 = ctrl_cnt;
        repeat (15) step();
        chk("post_rst_no_dot", 32'(dot_cnt - d0), 32'd0);
        chk("post_rst_no_ctrl", 32'(ctrl_cnt - c0), 32'd0);
        ack_delay = 3;

        // Randomized traffic checked cycle by cycle against the model.
        ack_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_data = ($urandom_range(0, 15) == 0) ? 8'h0D : 8'(8'h41 + $urandom_range(0, 25));
            ctrl_update = ($urandom_range(0, 19) == 0);
            ctrl_word_in = 8'($urandom);
            tick = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 49) == 0) scrolling_enable = ~scrolling_enable;
            step();
        end
        rx_valid = 1'b0;
        ctrl_update = 1'b0;
        tick = 1'b0;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_display_scheduler.md
Name: led_display_scheduler

Overview:
Sequences all register writes to the serial LED display driver (the led_write FSM). Received UART characters are buffered as a message. On each display tick, the block issues one dot-register write: the next character when scrolling, or all four characters when static. Control-word (brightness/config) updates are arbitrated against dot writes, and the block enforces one outstanding write at a time with a timeout.

Parameters:
MSG_DEPTH, 16, message buffer depth in characters (power of 2, at least 4)
TIMEOUT, 4095, led_clk cycles to wait for write_end before abandoning a write
PAD_CHAR, 8'h20, fill character for static positions beyond message length

Ports:
led_clk  in  1  system clock, all logic posedge
rstn  in  1  asynchronous active-low reset
rx_data  in  8  received character
rx_valid  in  1  one-cycle strobe, rx_data valid
ctrl_word_in  in  8  new control-register value
ctrl_update  in  1  one-cycle strobe, request control-register write
scrolling_enable  in  1  1 = scroll one char per tick, 0 = static 4-char display
tick  in  1  one-cycle refresh/scroll strobe
write_end  in  1  one-cycle pulse from driver, current write complete
control_write  out  1  one-cycle request to driver, control write
dot_write  out  1  one-cycle request to driver, dot write
control_word  out  8  registered control value presented to driver
char0..char3  out  8 each  characters presented to driver
msg_len  out  $clog2(MSG_DEPTH)+1  characters currently in buffer
overflow  out  1  sticky, character dropped on full buffer
timeout_err  out  1  sticky, write_end not seen within TIMEOUT

Behaviour:
- Reset values: all outputs 0, except control_word = 8'h4F and char0..3 = PAD_CHAR. FSM goes to IDLE; pointers, length and pending flags clear.
- Buffer (linear fill, index 0..MSG_DEPTH-1):
  - rx_valid with rx_data = 8'h0D: clears msg_len, scroll pointer and overflow next cycle. The CR itself is not stored.
  - rx_valid with any other byte while msg_len < MSG_DEPTH: write at index msg_len, msg_len++.
  - Buffer full: byte dropped, overflow <= 1.
  - Buffer writes are accepted in every FSM state.
- Pending flags:
  - ctrl_update sets ctrl_pend and captures ctrl_word_in into a shadow register (a later update overwrites the shadow).
  - tick sets tick_pend. Extra ticks while tick_pend = 1 are discarded.
  - A flag's set strobe and its own clear in the same cycle: set wins.
- FSM states IDLE, CTRL_REQ, CTRL_WAIT, DOT_REQ, DOT_WAIT:
  - IDLE: ctrl_pend -> CTRL_REQ, because control has priority over dot.
  - IDLE: else tick_pend and msg_len != 0 -> DOT_REQ.
  - IDLE: else tick_pend and msg_len == 0 -> clear tick_pend, stay IDLE.
  - CTRL_REQ: control_word <= shadow, control_write = 1 for exactly one cycle, clear ctrl_pend, start timer -> CTRL_WAIT.
  - DOT_REQ: load char0..3 (see below), dot_write = 1 for exactly one cycle, clear tick_pend, start timer -> DOT_WAIT.
  - *_WAIT: write_end -> IDLE. Timer reaching TIMEOUT -> timeout_err <= 1, -> IDLE. No new request is issued while in *_WAIT.
  - write_end in IDLE/*_REQ: ignored.
  - control_write and dot_write are never high together.
- Character load:
  - Scrolling: char0 = buf[sptr], char1..3 unchanged. sptr <= (sptr+1 == msg_len) ? 0 : sptr+1 (wraps to 0). If sptr >= msg_len after a CR, sptr is 0.
  - Static: charN = buf[N] if N < msg_len else PAD_CHAR. sptr unchanged.
- scrolling_enable is sampled in DOT_REQ only. A change mid-write takes effect on the next tick.
- Latency: tick in IDLE -> dot_write asserted 2 cycles later (pend register, then DOT_REQ).
- timeout_err and overflow clear only on rstn (overflow also clears on CR).
- Reset asserted mid-operation: immediate return to reset values, with no request pulse emitted.

Test Plan:
- Reset, then send "ABCDE" and pulse tick 6 times in scroll mode (ack each with write_end 3 cycles after dot_write) -> char0 sequence 41,42,43,44,45,41. Exactly 6 dot_write pulses, msg_len = 5.
- Static mode, message "HI", one tick -> char0..3 = 48,49,20,20. One dot_write two cycles after tick.
- ctrl_update(8'h3A) and tick in the same cycle from IDLE -> control_write first with control_word = 3A. After write_end, dot_write follows. Never both high.
- Send 17 chars with MSG_DEPTH = 16 -> msg_len = 16, overflow = 1. Then send 0x0D -> msg_len = 0, overflow = 0. A following tick produces no dot_write.
- dot_write issued, write_end withheld -> after TIMEOUT cycles timeout_err = 1 and FSM back in IDLE. The next tick issues a new dot_write.
- Pulse rstn low during DOT_WAIT -> outputs return to reset values (control_word = 4F, chars = 20, msg_len = 0) asynchronously. A late write_end after reset is ignored.
